// File: rtl/cube_expand_if.sv
// rtl/cube_expand_if.sv - request/result bundle for the cube root expander
interface cube_expand_if #(
  parameter int n = 32
);
  logic [10:0]  i_root;
  logic [n:0]   i_remainder;
  logic         i_vld;
  logic [n-1:0] o_data;
  logic         o_vld;
  logic         o_busy;
  logic         o_ovf;

  modport master (
    output i_root, i_remainder, i_vld,
    input  o_data, o_vld, o_busy, o_ovf
  );

  modport slave (
    input  i_root, i_remainder, i_vld,
    output o_data, o_vld, o_busy, o_ovf
  );
endinterface

// File: rtl/cube_expand.sv
// rtl/cube_expand.sv - rebuilds sign(root)*(|root|^3 + remainder) with serial shift-add multiplies
module cube_expand #(
  parameter int n = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  cube_expand_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SQ, CUBE, ADD} state_t;

  localparam logic [33:0] MAX_POS = (34'd1 << (n - 1)) - 34'd1;
  localparam logic [33:0] MAX_NEG = (34'd1 << (n - 1));

  state_t       state, state_next;
  logic [3:0]   cnt;
  logic         sign_r;
  logic [10:0]  mag_r;
  logic [n:0]   rem_r;
  logic [21:0]  sq_r;
  logic [32:0]  cube_r;
  logic [n-1:0] data_r;
  logic         vld_r;
  logic         ovf_r;

  logic         accept;
  logic         last_bit;
  logic [10:0]  mag_in;
  logic [21:0]  sq_add;
  logic [32:0]  cube_add;
  logic [33:0]  sum;
  logic [33:0]  neg_sum;

  assign accept   = (state == IDLE) && bus.i_vld;
  assign last_bit = (cnt == 4'd10);
  // -1024 negates to 0x400, which is exactly 1024 as an unsigned 11-bit magnitude.
  assign mag_in   = bus.i_root[10] ? (~bus.i_root + 11'd1) : bus.i_root;
  assign sq_add   = mag_r[cnt] ? ({11'd0, mag_r} << cnt) : 22'd0;
  assign cube_add = mag_r[cnt] ? ({11'd0, sq_r} << cnt) : 33'd0;
  assign sum      = {1'b0, cube_r} + 34'(rem_r);
  assign neg_sum  = ~sum + 34'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.i_vld) state_next = SQ;
      SQ:      if (last_bit)  state_next = CUBE;
      CUBE:    if (last_bit)  state_next = ADD;
      ADD:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= 4'd0;
      sign_r <= 1'b0;
      mag_r  <= 11'd0;
      rem_r  <= '0;
      sq_r   <= 22'd0;
      cube_r <= 33'd0;
      data_r <= '0;
      vld_r  <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      vld_r <= 1'b0;
      if (accept) begin
        sign_r <= bus.i_root[10];
        mag_r  <= mag_in;
        rem_r  <= bus.i_remainder;
        cnt    <= 4'd0;
        sq_r   <= 22'd0;
        cube_r <= 33'd0;
      end
      case (state)
        SQ: begin
          sq_r <= sq_r + sq_add;
          cnt  <= last_bit ? 4'd0 : cnt + 4'd1;
        end
        CUBE: begin
          cube_r <= cube_r + cube_add;
          cnt    <= last_bit ? 4'd0 : cnt + 4'd1;
        end
        ADD: begin
          vld_r <= 1'b1;
          if (sign_r) begin
            data_r <= neg_sum[n-1:0];
            ovf_r  <= (sum > MAX_NEG);
          end else begin
            data_r <= sum[n-1:0];
            ovf_r  <= (sum > MAX_POS);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_data = data_r;
  assign bus.o_vld  = vld_r;
  assign bus.o_ovf  = ovf_r;
  assign bus.o_busy = (state != IDLE);
endmodule

// File: tb/tb_cube_expand.sv
// tb/tb_cube_expand.sv - randomized and directed checks of cube_expand against an arithmetic model
module tb_cube_expand;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  logic [31:0] last_data;
  logic        last_ovf;

  localparam longint LIM = 64'd2147483648;

  cube_expand_if #(.n(32)) bus ();

  cube_expand #(.n(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [32:0] model(input logic [10:0] root, input logic [32:0] rem);
    longint r, m, s, v;
    logic   ovf;
    r = longint'($signed(root));
    m = (r < 0) ? -r : r;
    s = m * m * m + longint'(rem);
    v = (r < 0) ? -s : s;
    ovf = (r < 0) ? (s > LIM) : (s > LIM - 1);
    return {ovf, v[31:0]};
  endfunction

  // Issues one request from a point away from the edge and leaves the bench inside the o_vld cycle.
  task automatic run_req(input string tag, input logic [10:0] root, input logic [32:0] rem,
                         input logic [31:0] exp_data, input logic exp_ovf, input bit inject);
    int k;
    bit seen;
    bit busy_ok;
    bus.i_root      = root;
    bus.i_remainder = rem;
    bus.i_vld       = 1'b1;
    @(posedge clk); #1;
    bus.i_vld = 1'b0;
    k = 0; seen = 0; busy_ok = 1;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (bus.o_vld) seen = 1;
      else begin
        if (!bus.o_busy) busy_ok = 0;
        if (inject && (k == 5 || k == 20)) begin
          bus.i_root      = 11'($urandom);
          bus.i_remainder = 33'($urandom);
          bus.i_vld       = 1'b1;
        end else bus.i_vld = 1'b0;
      end
    end
    check($sformatf("%s_latency", tag), 64'(k), 64'd23);
    check($sformatf("%s_busy_run", tag), 64'(busy_ok), 64'd1);
    check($sformatf("%s_busy_vld", tag), 64'(bus.o_busy), 64'd0);
    check($sformatf("%s_data", tag), 64'(bus.o_data), 64'(exp_data));
    check($sformatf("%s_ovf", tag), 64'(bus.o_ovf), 64'(exp_ovf));
    last_data = exp_data;
    last_ovf  = exp_ovf;
  endtask

  task automatic idle_hold(input string tag, input int cycles);
    bus.i_vld = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    check($sformatf("%s_vld_low", tag), 64'(bus.o_vld), 64'd0);
    check($sformatf("%s_data_hold", tag), 64'(bus.o_data), 64'(last_data));
    check($sformatf("%s_ovf_hold", tag), 64'(bus.o_ovf), 64'(last_ovf));
  endtask

  task automatic run_model(input string tag, input logic [10:0] root, input logic [32:0] rem);
    logic [32:0] e;
    e = model(root, rem);
    run_req(tag, root, rem, e[31:0], e[32], 1'b0);
  endtask

  initial begin
    logic [63:0] rnd;
    logic [32:0] rem;
    logic [10:0] root;
    int seen_vld;
    pass_cnt = 0;
    total_cnt = 0;
    last_data = '0;
    last_ovf = 1'b0;
    rst_n = 1'b0;
    bus.i_root = '0;
    bus.i_remainder = '0;
    bus.i_vld = 1'b0;
    #22;
    check("rst_data", 64'(bus.o_data), 64'd0);
    check("rst_vld", 64'(bus.o_vld), 64'd0);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_ovf", 64'(bus.o_ovf), 64'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    run_req("r5", 11'd5, 33'd3, 32'h0000_0080, 1'b0, 1'b0);
    idle_hold("r5", 3);
    run_req("rm3", 11'h7FD, 33'd0, 32'hFFFF_FFE5, 1'b0, 1'b0);
    idle_hold("rm3", 1);
    run_req("max", 11'd1023, 33'd0, 32'd1070599167, 1'b0, 1'b0);
    run_req("min", 11'h400, 33'd0, 32'hC000_0000, 1'b0, 1'b0);
    run_req("ovf", 11'd1023, 33'd1076884481, 32'h8000_0000, 1'b1, 1'b0);
    run_req("zero", 11'd0, 33'd77, 32'd77, 1'b0, 1'b0);
    run_req("inject", 11'd7, 33'd1, 32'd344, 1'b0, 1'b1);
    run_req("b2b", 11'h7FE, 33'd5, 32'hFFFF_FFF3, 1'b0, 1'b0);
    idle_hold("b2b", 2);

    for (int i = 0; i < 20; i++) begin
      rnd  = {$urandom, $urandom};
      root = rnd[10:0];
      rem  = ($urandom_range(0, 2) == 0) ? rnd[44:12] : 33'(rnd[27:12]);
      run_model($sformatf("rand%0d", i), root, rem);
      if ($urandom_range(0, 1) == 1) idle_hold($sformatf("rand%0d", i), $urandom_range(1, 3));
    end

    bus.i_root = 11'd9;
    bus.i_remainder = 33'd4;
    bus.i_vld = 1'b1;
    @(posedge clk); #1;
    bus.i_vld = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 64'(bus.o_data), 64'd0);
    check("mid_rst_vld", 64'(bus.o_vld), 64'd0);
    check("mid_rst_busy", 64'(bus.o_busy), 64'd0);
    check("mid_rst_ovf", 64'(bus.o_ovf), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_vld = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.o_vld || bus.o_busy) seen_vld++;
    end
    check("no_vld_after_rst", 64'(seen_vld), 64'd0);
    run_model("after_rst", 11'h5A5, 33'd12345);

    bus.i_root = 11'd100;
    bus.i_remainder = 33'd0;
    bus.i_vld = 1'b1;
    @(posedge clk); #1;
    bus.i_vld = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_model("first_after_rst", 11'd200, 33'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
